// File: rtl/itrx_aib_phy_jtag_pkg.sv
// Shared definitions for the AIB PHY JTAG TAP: state encodings, widths and opcode helpers.
package itrx_aib_phy_jtag_pkg;

    localparam int unsigned TAP_STATE_W = 4;
    localparam int unsigned IDCODE_W    = 32;
    localparam int unsigned MAX_IR_W    = 16;

    // IEEE 1149.1 TAP controller states; Test-Logic-Reset must stay at zero
    localparam logic [TAP_STATE_W-1:0] TAP_TLR       = 4'h0;
    localparam logic [TAP_STATE_W-1:0] TAP_RTI       = 4'h1;
    localparam logic [TAP_STATE_W-1:0] TAP_SEL_DR    = 4'h2;
    localparam logic [TAP_STATE_W-1:0] TAP_CAP_DR    = 4'h3;
    localparam logic [TAP_STATE_W-1:0] TAP_SHIFT_DR  = 4'h4;
    localparam logic [TAP_STATE_W-1:0] TAP_EXIT1_DR  = 4'h5;
    localparam logic [TAP_STATE_W-1:0] TAP_PAUSE_DR  = 4'h6;
    localparam logic [TAP_STATE_W-1:0] TAP_EXIT2_DR  = 4'h7;
    localparam logic [TAP_STATE_W-1:0] TAP_UPDATE_DR = 4'h8;
    localparam logic [TAP_STATE_W-1:0] TAP_SEL_IR    = 4'h9;
    localparam logic [TAP_STATE_W-1:0] TAP_CAP_IR    = 4'hA;
    localparam logic [TAP_STATE_W-1:0] TAP_SHIFT_IR  = 4'hB;
    localparam logic [TAP_STATE_W-1:0] TAP_EXIT1_IR  = 4'hC;
    localparam logic [TAP_STATE_W-1:0] TAP_PAUSE_IR  = 4'hD;
    localparam logic [TAP_STATE_W-1:0] TAP_EXIT2_IR  = 4'hE;
    localparam logic [TAP_STATE_W-1:0] TAP_UPDATE_IR = 4'hF;

    // BYPASS is the all-ones opcode; callers truncate to their IR width
    function automatic logic [MAX_IR_W-1:0] bypass_opc(input int unsigned ir_width);
        return MAX_IR_W'((32'd1 << ir_width) - 32'd1);
    endfunction

endpackage

// File: rtl/itrx_aib_phy_jtag_fsm.sv
// TAP controller: 16-state 1149.1 state register and TMS-driven next-state logic.
module itrx_aib_phy_jtag_fsm
    import itrx_aib_phy_jtag_pkg::*;
(
    input  logic                   tck,
    input  logic                   reset,
    input  logic                   tms,
    output logic [TAP_STATE_W-1:0] state,
    output logic [TAP_STATE_W-1:0] next_state
);

    logic [TAP_STATE_W-1:0] state_q;
    logic [TAP_STATE_W-1:0] state_d;

    always_comb begin
        state_d = TAP_TLR;
        case (state_q)
            TAP_TLR:       state_d = tms ? TAP_TLR       : TAP_RTI;
            TAP_RTI:       state_d = tms ? TAP_SEL_DR    : TAP_RTI;
            TAP_SEL_DR:    state_d = tms ? TAP_SEL_IR    : TAP_CAP_DR;
            TAP_CAP_DR:    state_d = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:  state_d = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:  state_d = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:  state_d = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:  state_d = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR: state_d = tms ? TAP_SEL_DR    : TAP_RTI;
            TAP_SEL_IR:    state_d = tms ? TAP_TLR       : TAP_CAP_IR;
            TAP_CAP_IR:    state_d = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:  state_d = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:  state_d = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:  state_d = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:  state_d = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR: state_d = tms ? TAP_SEL_DR    : TAP_RTI;
            default:       state_d = TAP_TLR;
        endcase
    end

    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    assign state      = state_q;
    assign next_state = state_d;

endmodule

// File: rtl/itrx_aib_phy_jtag_tap.sv
// AIB PHY JTAG TAP: instruction register, BYPASS/IDCODE data registers and
// the falling-edge TDO retime around the shared TAP controller.
module itrx_aib_phy_jtag_tap
    import itrx_aib_phy_jtag_pkg::*;
#(
    parameter int unsigned          IR_WIDTH   = 7,
    parameter logic [31:0]          IDCODE_VAL = 32'h0000_1FFF,
    parameter logic [IR_WIDTH-1:0]  IDCODE_OPC = IR_WIDTH'(7'h01)
) (
    input  logic                tck,
    input  logic                reset,
    input  logic                tms,
    input  logic                tdi,
    input  logic                ext_tdo,
    output logic                tdo,
    output logic                tdo_en,
    output logic [IR_WIDTH-1:0] instruction,
    output logic                capture_dr,
    output logic                shift_dr,
    output logic                update_dr,
    output logic                shift_ir,
    output logic                update_ir,
    output logic                test_logic_reset,
    output logic                state_shift_dr_p,
    output logic                sel_ext_dr
);

    localparam logic [IR_WIDTH-1:0] BYPASS_OPC  = IR_WIDTH'(bypass_opc(IR_WIDTH));
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(2'b01);

    logic [TAP_STATE_W-1:0] state;
    logic [TAP_STATE_W-1:0] next_state;

    logic [IR_WIDTH-1:0]    ir_sr_q, ir_sr_d;
    logic [IR_WIDTH-1:0]    instruction_q, instruction_d;
    logic                   bypass_q, bypass_d;
    logic [IDCODE_W-1:0]    idcode_q, idcode_d;
    logic                   tdo_q, tdo_d;
    logic                   tdo_en_q, tdo_en_d;
    logic                   sel_bypass;
    logic                   sel_idcode;
    logic                   dr_tdo;

    itrx_aib_phy_jtag_fsm u_fsm (
        .tck        (tck),
        .reset      (reset),
        .tms        (tms),
        .state      (state),
        .next_state (next_state)
    );

    assign capture_dr       = (state == TAP_CAP_DR);
    assign shift_dr         = (state == TAP_SHIFT_DR);
    assign update_dr        = (state == TAP_UPDATE_DR);
    assign shift_ir         = (state == TAP_SHIFT_IR);
    assign update_ir        = (state == TAP_UPDATE_IR);
    assign test_logic_reset = (state == TAP_TLR);
    assign state_shift_dr_p = (next_state == TAP_SHIFT_DR);

    // BYPASS wins if an integrator ever sets IDCODE_OPC to all ones
    assign sel_bypass = (instruction_q == BYPASS_OPC);
    assign sel_idcode = !sel_bypass && (instruction_q == IDCODE_OPC);
    assign sel_ext_dr = !sel_bypass && !sel_idcode;

    always_comb begin
        ir_sr_d  = ir_sr_q;
        bypass_d = bypass_q;
        idcode_d = idcode_q;
        if (state == TAP_CAP_IR) begin
            ir_sr_d = IR_CAPTURE;
        end else if (state == TAP_SHIFT_IR) begin
            ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
        end
        if (sel_bypass) begin
            if (state == TAP_CAP_DR) begin
                bypass_d = 1'b0;
            end else if (state == TAP_SHIFT_DR) begin
                bypass_d = tdi;
            end
        end
        if (sel_idcode) begin
            if (state == TAP_CAP_DR) begin
                idcode_d = IDCODE_VAL;
            end else if (state == TAP_SHIFT_DR) begin
                idcode_d = {tdi, idcode_q[IDCODE_W-1:1]};
            end
        end
    end

    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            ir_sr_q  <= '0;
            bypass_q <= 1'b0;
            idcode_q <= IDCODE_VAL;
        end else begin
            ir_sr_q  <= ir_sr_d;
            bypass_q <= bypass_d;
            idcode_q <= idcode_d;
        end
    end

    // Falling-edge side: instruction update and TDO retime half a cycle after the shift
    always_comb begin
        dr_tdo = ext_tdo;
        if (sel_bypass) begin
            dr_tdo = bypass_q;
        end else if (sel_idcode) begin
            dr_tdo = idcode_q[0];
        end

        instruction_d = instruction_q;
        if (state == TAP_TLR) begin
            instruction_d = IDCODE_OPC;
        end else if (state == TAP_UPDATE_IR) begin
            instruction_d = ir_sr_q;
        end

        tdo_d    = 1'b0;
        tdo_en_d = 1'b0;
        if (state == TAP_SHIFT_IR) begin
            tdo_d    = ir_sr_q[0];
            tdo_en_d = 1'b1;
        end else if (state == TAP_SHIFT_DR) begin
            tdo_d    = dr_tdo;
            tdo_en_d = 1'b1;
        end
    end

    always_ff @(negedge tck or posedge reset) begin
        if (reset) begin
            instruction_q <= IDCODE_OPC;
            tdo_q         <= 1'b0;
            tdo_en_q      <= 1'b0;
        end else begin
            instruction_q <= instruction_d;
            tdo_q         <= tdo_d;
            tdo_en_q      <= tdo_en_d;
        end
    end

    assign instruction = instruction_q;
    assign tdo         = tdo_q;
    assign tdo_en      = tdo_en_q;

endmodule

// File: tb/tb_itrx_aib_phy_jtag_tap.sv
// Directed bench for itrx_aib_phy_jtag_tap: default 7-bit IR instance and a 4-bit IR instance.
module tb_itrx_aib_phy_jtag_tap;

    logic       tck = 1'b0;
    logic       reset = 1'b0;
    logic       tms_a = 1'b1, tdi_a = 1'b0;
    logic       tms_b = 1'b1, tdi_b = 1'b0;
    logic       ext_tdo = 1'b0;
    int         cur = 0;
    int         n_assert = 0;
    int         n_fail = 0;

    logic       tdo_a, tdo_en_a, cdr_a, sdr_a, udr_a, sir_a, uir_a, tlr_a, pdr_a, ext_a;
    logic       tdo_b, tdo_en_b, cdr_b, sdr_b, udr_b, sir_b, uir_b, tlr_b, pdr_b, ext_b;
    logic [6:0] instr_a;
    logic [3:0] instr_b;

    itrx_aib_phy_jtag_tap u_dut_a (
        .tck(tck), .reset(reset), .tms(tms_a), .tdi(tdi_a), .ext_tdo(ext_tdo),
        .tdo(tdo_a), .tdo_en(tdo_en_a), .instruction(instr_a),
        .capture_dr(cdr_a), .shift_dr(sdr_a), .update_dr(udr_a),
        .shift_ir(sir_a), .update_ir(uir_a), .test_logic_reset(tlr_a),
        .state_shift_dr_p(pdr_a), .sel_ext_dr(ext_a)
    );

    itrx_aib_phy_jtag_tap #(.IR_WIDTH(4), .IDCODE_OPC(4'h2)) u_dut_b (
        .tck(tck), .reset(reset), .tms(tms_b), .tdi(tdi_b), .ext_tdo(ext_tdo),
        .tdo(tdo_b), .tdo_en(tdo_en_b), .instruction(instr_b),
        .capture_dr(cdr_b), .shift_dr(sdr_b), .update_dr(udr_b),
        .shift_ir(sir_b), .update_ir(uir_b), .test_logic_reset(tlr_b),
        .state_shift_dr_p(pdr_b), .sel_ext_dr(ext_b)
    );

    always #10 tck = ~tck;

    logic        tdo_s, tdo_en_s, cdr_s, sdr_s, udr_s, sir_s, uir_s, tlr_s, pdr_s, ext_s;
    logic [15:0] instr_s;
    assign tdo_s    = (cur == 0) ? tdo_a    : tdo_b;
    assign tdo_en_s = (cur == 0) ? tdo_en_a : tdo_en_b;
    assign cdr_s    = (cur == 0) ? cdr_a    : cdr_b;
    assign sdr_s    = (cur == 0) ? sdr_a    : sdr_b;
    assign udr_s    = (cur == 0) ? udr_a    : udr_b;
    assign sir_s    = (cur == 0) ? sir_a    : sir_b;
    assign uir_s    = (cur == 0) ? uir_a    : uir_b;
    assign tlr_s    = (cur == 0) ? tlr_a    : tlr_b;
    assign pdr_s    = (cur == 0) ? pdr_a    : pdr_b;
    assign ext_s    = (cur == 0) ? ext_a    : ext_b;
    assign instr_s  = (cur == 0) ? 16'(instr_a) : 16'(instr_b);

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%b expected=%b", tag, cur, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, cur, obs, exp);
        end
    endtask

    // One TCK cycle on the selected instance; returns 1 ns after the falling edge
    task automatic tick(input logic m, input logic d);
        if (cur == 0) begin
            tms_a = m; tdi_a = d;
        end else begin
            tms_b = m; tdi_b = d;
        end
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic run_suite(input int which, input int n, input logic [15:0] opc);
        logic [31:0] word;
        logic        en_all;
        logic [15:0] ones;
        logic [15:0] val;
        int          k;
        cur    = which;
        ones   = 16'((32'd1 << n) - 32'd1);
        val    = 16'h5555 & ones;
        k      = n / 2;
        word   = '0;
        en_all = 1'b1;
        tms_a  = 1'b1; tms_b = 1'b1; tdi_a = 1'b0; tdi_b = 1'b0; ext_tdo = 1'b0;

        // asynchronous reset values
        reset = 1'b0; #1; reset = 1'b1; #3;
        chk1("rst_tlr", tlr_s, 1'b1);
        chkw("rst_instr", 32'(instr_s), 32'(opc));
        chk1("rst_tdo", tdo_s, 1'b0);
        chk1("rst_tdo_en", tdo_en_s, 1'b0);
        chk1("rst_sel_ext", ext_s, 1'b0);
        @(negedge tck); #2; reset = 1'b0;
        tick(1, 0);
        chk1("idle_tlr", tlr_s, 1'b1);

        // IDCODE read straight after reset
        tick(0, 0); tick(1, 0); tick(0, 0);
        chk1("cap_dr", cdr_s, 1'b1);
        chk1("shift_dr_p", pdr_s, 1'b1);
        tick(0, 0);
        chk1("shift_dr", sdr_s, 1'b1);
        for (int i = 0; i < 32; i++) begin
            word[i] = tdo_s;
            en_all  = en_all & tdo_en_s;
            tick((i == 31) ? 1'b1 : 1'b0, 1'b0);
        end
        chkw("idcode_word", word, 32'h0000_1FFF);
        chk1("idcode_tdo_en", en_all, 1'b1);
        chk1("exit1dr_tdo_en", tdo_en_s, 1'b0);

        // Load BYPASS with a Pause-IR excursion in the middle of the shift
        tick(1, 0);
        chk1("update_dr", udr_s, 1'b1);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        chk1("shift_ir", sir_s, 1'b1);
        chk1("ir_cap_bit0", tdo_s, 1'b1);
        chk1("ir_tdo_en", tdo_en_s, 1'b1);
        for (int i = 0; i < k - 1; i++) tick(0, 1);
        tick(1, 1);
        tick(0, 0);
        chkw("pause_ir_instr", 32'(instr_s), 32'(opc));
        tick(1, 0); tick(0, 0);
        chk1("resume_shift_ir", sir_s, 1'b1);
        chk1("resume_ir_tdo", tdo_s, 1'b0);
        for (int i = 0; i < n - k - 1; i++) tick(0, 1);
        tick(1, 1);
        chkw("exit1ir_instr", 32'(instr_s), 32'(opc));
        tick(1, 0);
        chk1("update_ir", uir_s, 1'b1);
        chkw("bypass_instr", 32'(instr_s), 32'(ones));
        chk1("bypass_sel_ext", ext_s, 1'b0);

        // BYPASS data path: tdi 1,0,1 -> tdo 0,1,0
        tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        chk1("byp_tdo0", tdo_s, 1'b0);
        tick(0, 1);
        chk1("byp_tdo1", tdo_s, 1'b1);
        tick(0, 0);
        chk1("byp_tdo2", tdo_s, 1'b0);
        tick(1, 1);

        // Shift zeros into IR: capture pattern then external DR selection
        tick(1, 0); tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        chk1("zir_tdo0", tdo_s, 1'b1);
        tick(0, 0);
        chk1("zir_tdo1", tdo_s, 1'b0);
        for (int i = 0; i < n - 2; i++) tick(0, 0);
        tick(1, 0);
        tick(1, 0);
        chkw("ext_instr", 32'(instr_s), 32'd0);
        chk1("ext_sel", ext_s, 1'b1);
        tick(0, 0);
        chk1("rti_shift_dr_p", pdr_s, 1'b0);
        tick(1, 0); tick(0, 0);
        ext_tdo = 1'b1; tick(0, 0);
        chk1("ext_tdo1", tdo_s, 1'b1);
        ext_tdo = 1'b0; tick(0, 0);
        chk1("ext_tdo0", tdo_s, 1'b0);
        ext_tdo = 1'b1; tick(0, 0);
        chk1("ext_tdo1b", tdo_s, 1'b1);
        ext_tdo = 1'b0;

        // Five TMS=1 from Pause-DR reach Test-Logic-Reset
        tick(1, 0); tick(0, 0);
        chk1("pause_dr_not_shift", sdr_s, 1'b0);
        for (int i = 0; i < 5; i++) tick(1, 0);
        chk1("tms5_tlr", tlr_s, 1'b1);
        chkw("tms5_instr", 32'(instr_s), 32'(opc));

        // Load a non-IDCODE opcode, then reset in the middle of an IR shift
        tick(0, 0); tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < n; i++) tick((i == n - 1) ? 1'b1 : 1'b0, val[i]);
        tick(1, 0);
        chkw("val_instr", 32'(instr_s), 32'(val));
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        tick(0, 1); tick(0, 1); tick(0, 1);
        chk1("mid_shift_en", tdo_en_s, 1'b1);
        #3; reset = 1'b1; #1;
        chk1("abort_tlr", tlr_s, 1'b1);
        chk1("abort_tdo_en", tdo_en_s, 1'b0);
        chk1("abort_shift_ir", sir_s, 1'b0);
        chkw("abort_instr", 32'(instr_s), 32'(opc));
        #2; reset = 1'b0;
        tms_a = 1'b1; tms_b = 1'b1;
        tick(1, 0);
        chk1("post_abort_update_ir", uir_s, 1'b0);
        chkw("post_abort_instr", 32'(instr_s), 32'(opc));
    endtask

    initial begin
        run_suite(0, 7, 16'h0001);
        run_suite(1, 4, 16'h0002);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
